s2p_aligner: RTL

- Receive side of the 4-lane serial link; sits directly downstream of the parallel-to-serial stage and consumes its 4-bit per-cycle serial output (one bit per lane).
- Each lane is deserialised into bytes, aligned to a COM symbol, and presented as four 8-bit parallel words with per-lane valid and lock flags.
- Lanes align independently. `all_lock` reports when the whole link is usable.

---
 rtl/s2p_aligner.sv | 93 +++++++++
 1 files changed

// File: rtl/s2p_aligner.sv
// Four-lane serial-to-parallel receiver: deserialises each lane LSB-first,
// aligns it to a COM symbol, and reports per-lane and whole-link lock.
module s2p_aligner #(
   parameter logic [7:0] COM          = 8'hBC,
   parameter int         LOCK_TIMEOUT = 16
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       ENB,
   input  logic [3:0] data_in,
   output logic [7:0] D0,
   output logic [7:0] D1,
   output logic [7:0] D2,
   output logic [7:0] D3,
   output logic [3:0] valid,
   output logic [3:0] lock,
   output logic       all_lock
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [7:0] TMO_LAST = 8'(LOCK_TIMEOUT - 1);

   logic all_lock_q;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      state_t     state_q;
      logic [7:0] sr_q;
      logic [7:0] sr_d;
      logic [7:0] byte_q;
      logic [2:0] bcnt_q;
      logic [7:0] tcnt_q;
      logic       valid_q;

      // Newest bit enters at the MSB, so after 8 bits bit 0 is the first one sent.
      assign sr_d = {data_in[g], sr_q[7:1]};

      always_ff @(posedge CLK) begin
         if (reset) begin
            state_q <= HUNT;
            sr_q    <= 8'h00;
            byte_q  <= 8'h00;
            bcnt_q  <= 3'd0;
            tcnt_q  <= 8'd0;
            valid_q <= 1'b0;
         end else if (!ENB) begin
            valid_q <= 1'b0;
         end else begin
            sr_q    <= sr_d;
            valid_q <= 1'b0;
            if (state_q == HUNT) begin
               if (sr_d == COM) begin
                  state_q <= LOCKED;
                  byte_q  <= COM;
                  valid_q <= 1'b1;
                  bcnt_q  <= 3'd0;
                  tcnt_q  <= 8'd0;
               end
            end else begin
               bcnt_q <= bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) begin
                  byte_q  <= sr_d;
                  valid_q <= 1'b1;
                  if (sr_d == COM) begin
                     tcnt_q <= 8'd0;
                  end else if (tcnt_q == TMO_LAST) begin
                     // Last byte before timeout is still delivered; lock drops with it.
                     state_q <= HUNT;
                     tcnt_q  <= 8'd0;
                  end else begin
                     tcnt_q <= tcnt_q + 8'd1;
                  end
               end
            end
         end
      end

      assign valid[g] = valid_q;
      assign lock[g]  = (state_q == LOCKED);
   end

   always_ff @(posedge CLK) begin
      if (reset) all_lock_q <= 1'b0;
      else       all_lock_q <= &lock;
   end

   assign all_lock = all_lock_q;
   assign D0 = g_lane[0].byte_q;
   assign D1 = g_lane[1].byte_q;
   assign D2 = g_lane[2].byte_q;
   assign D3 = g_lane[3].byte_q;

endmodule
